csu_array_seq: RTL and testbench
================================

CSU_ARRAY_SEQ -- requirements
Module: csu_array_seq

Interface
REQ-001 SHALL expose parameter N_THERM, default 17, number of thermometer current units (1..32).
REQ-002 SHALL expose parameter N_BIN, default 6, number of binary-weighted current bits (1..8).
REQ-003 SHALL expose parameter SETTLE_CYC, default 16, power-up ramp length in clocks (>=1).
REQ-004 SHALL expose parameter DEBOUNCE_CYC, default 4, consecutive out-of-window samples that raise a fault (>=1).
REQ-005 SHALL expose parameter IREF_NOM, default 500e-6, nominal reference current in A.
REQ-006 SHALL expose parameter NOISE_EN, default 0; 1 adds Gaussian noise (sigma 1 nA per LSB unit, scaled by sqrt of unit weight).
REQ-007 SHALL have ports: one clock; reset is asynchronous and active-low.
  clk  in  1  block clock, all state updates on rising edge
  rstb  in  1  asynchronous active-low reset
  pdb  in  1  power-down negated; 1 = enable
  therm_ena  in  N_THERM  per-unit thermometer enable
  atb_ena  in  2  analog testbus mode
  atb_sel  in  5  thermometer unit routed to atb0 in mode 2'b10
  iref_500ua, vddana_1p8, vddana_0p8, vssana  in  real  reference current and supplies
  iout_therm[N_THERM]  out  real  thermometer unit currents
  iout_bin[N_BIN]  out  real  binary currents, index N_BIN-1 = MSB
  iout_bin_red  out  real  redundant LSB current
  atb1, atb0  out  real  analog testbus
  ready  out  1  ramp complete, outputs at nominal
  fault  out  1  supply/reference fault latched
  state  out  2  FSM state: 0 OFF, 1 SETTLE, 2 ON, 3 FAULT

Function
REQ-008 SHALL sample every clk: inputs OK when iref within IREF_NOM +/-10%, vddana_1p8 within 1.8 V +/-5%, vddana_0p8 within 0.8 V +/-5%, vssana within +/-0.05 V (bounds inclusive).
REQ-009 SHALL maintain a bad-sample counter in SETTLE/ON: increment on a not-OK sample, clear on an OK sample, saturate at DEBOUNCE_CYC; reaching DEBOUNCE_CYC forces FAULT next edge.
REQ-010 SHALL transition OFF->SETTLE when pdb=1 and the current sample is OK; otherwise stay OFF (no fault counting in OFF).
REQ-011 SHALL in SETTLE advance ramp counter k=1..SETTLE_CYC, one step per clock; after the cycle with k=SETTLE_CYC, go to ON.
REQ-012 SHALL in ON hold outputs at nominal and ready=1; leave only via FAULT or pdb=0.
REQ-013 SHALL in FAULT drive all current outputs 0.0, fault=1, ready=0; exit only to OFF on pdb=0; fault clears on entering OFF.
REQ-014 SHALL go to OFF on the next edge whenever pdb=0 in any state; pdb=0 wins over a simultaneous fault.
REQ-015 SHALL compute nominal unit values: therm = iref/2.5; iout_bin[b] = iref/(2.5*2^(N_BIN-b)); iout_bin_red = iout_bin[0].
REQ-016 SHALL scale all current outputs in SETTLE by k/SETTLE_CYC; therm units with therm_ena=0 drive 0.0 in SETTLE and ON.
REQ-017 SHALL register all outputs: a change on any input appears on outputs one clock later.
REQ-018 SHALL drive all current outputs wrealZState in OFF.
REQ-019 SHALL drive atb per atb_ena: 00 both Z; 01 atb1=vddana_1p8, atb0=vssana; 10 atb1=vddana_0p8, atb0=iout_therm[atb_sel] (0.0 if atb_sel>=N_THERM); 11 atb1=iref_500ua, atb0=iout_bin_red; in OFF both Z regardless of atb_ena.
REQ-020 SHALL issue $warning once per entry into FAULT reporting which check failed.

Reset
REQ-021 SHALL on rstb=0 immediately set state=OFF, ready=0, fault=0, counters 0, all current and atb outputs wrealZState; operation resumes from OFF on the first edge after rstb=1, including reset mid-ramp.

Verification (SETTLE_CYC=4, DEBOUNCE_CYC=3, NOISE_EN=0, nominal supplies)
REQ-022 SHALL cover power-up: iref=500 uA, pdb 0->1 -> iout_therm[0]=50,100,150,200 uA over 4 edges, then ready=1, iout_bin[5]=100 uA, iout_bin_red=3.125 uA.
REQ-023 SHALL cover debounce: in ON, vddana_1p8=1.6 V for 2 cycles then 1.8 V -> no fault; 3 cycles -> state=3, fault=1, all currents 0.0.
REQ-024 SHALL cover fault exit: in FAULT, pdb=0 -> next edge state=0, fault=0, outputs Z; pdb=1 -> new ramp from 50 uA.
REQ-025 SHALL cover testbus: in ON, therm_ena[3]=0, atb_ena=10, atb_sel=3 -> atb0=0.0, atb1=0.8 V; atb_sel=20 -> atb0=0.0; atb_ena=11 -> atb1=500 uA, atb0=3.125 uA.
REQ-026 SHALL cover async reset at k=2 of SETTLE: rstb=0 -> outputs Z without clock; after release with pdb=1 -> ramp restarts at k=1.
REQ-027 SHALL cover simultaneous pdb=0 and third bad sample -> state=OFF, fault=0.

Source files
------------

// File: rtl/csu_array_seq.sv
// Segmented current-steering array: supply/reference supervision,
// power-up ramp, fault latch and analog testbus routing.
module csu_array_seq #(
    parameter int  N_THERM      = 17,
    parameter int  N_BIN        = 6,
    parameter int  SETTLE_CYC   = 16,
    parameter int  DEBOUNCE_CYC = 4,
    parameter real IREF_NOM     = 500e-6,
    parameter int  NOISE_EN     = 0
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               pdb,
    input  logic [N_THERM-1:0] therm_ena,
    input  logic [1:0]         atb_ena,
    input  logic [4:0]         atb_sel,
    input  real                iref_500ua,
    input  real                vddana_1p8,
    input  real                vddana_0p8,
    input  real                vssana,
    output real                iout_therm [N_THERM],
    output real                iout_bin [N_BIN],
    output real                iout_bin_red,
    output real                atb1,
    output real                atb0,
    output logic               ready,
    output logic               fault,
    output logic [1:0]         state
);

    // Plain SV has no real-valued high-Z; this sentinel stands in for wrealZState.
    localparam real Z_REAL = 1.0e30;
    localparam int  KW     = $clog2(SETTLE_CYC + 1);
    localparam int  BW     = $clog2(DEBOUNCE_CYC + 1);

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_SETTLE = 2'd1,
        S_ON     = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    state_t          state_q, state_n;
    logic [KW-1:0]   k_q, k_n;
    logic [BW-1:0]   bad_q, bad_n, bad_sat;
    logic [31:0]     lfsr_q;
    logic            iref_ok, v18_ok, v08_ok, vss_ok, ok;
    real             scale, unit, nz;
    real             therm_n [N_THERM];
    real             bin_n [N_BIN];
    real             red_n, atb1_n, atb0_n, sel_val;

    always_comb begin
        iref_ok = (iref_500ua >= 0.9 * IREF_NOM) && (iref_500ua <= 1.1 * IREF_NOM);
        v18_ok  = (vddana_1p8 >= 1.71) && (vddana_1p8 <= 1.89);
        v08_ok  = (vddana_0p8 >= 0.76) && (vddana_0p8 <= 0.84);
        vss_ok  = (vssana >= -0.05) && (vssana <= 0.05);
        ok      = iref_ok && v18_ok && v08_ok && vss_ok;
        bad_sat = (bad_q == BW'(DEBOUNCE_CYC)) ? bad_q : bad_q + 1'b1;
        state_n = state_q;
        k_n     = k_q;
        bad_n   = '0;
        unique case (state_q)
            S_OFF: begin
                if (pdb && ok) begin
                    state_n = S_SETTLE;
                    k_n     = KW'(1);
                end
            end
            S_SETTLE: begin
                bad_n = ok ? '0 : bad_sat;
                if (k_q == KW'(SETTLE_CYC)) begin
                    state_n = S_ON;
                    k_n     = '0;
                end else begin
                    k_n = k_q + 1'b1;
                end
            end
            S_ON:    bad_n = ok ? '0 : bad_sat;
            S_FAULT: bad_n = '0;
            default: state_n = S_OFF;
        endcase
        if (bad_n == BW'(DEBOUNCE_CYC)) begin
            state_n = S_FAULT;
            k_n     = '0;
            bad_n   = '0;
        end
        // Power-down overrides everything, including a fault on the same edge.
        if (!pdb) begin
            state_n = S_OFF;
            k_n     = '0;
            bad_n   = '0;
        end
    end

    // Approximate N(0,1) from four uniform bytes (central limit).
    always_comb begin
        nz = 0.0;
        if (NOISE_EN != 0) begin
            nz = 1.0e-9 * (real'(int'(lfsr_q[7:0]) + int'(lfsr_q[15:8])
                 + int'(lfsr_q[23:16]) + int'(lfsr_q[31:24])) - 510.0) / 147.8;
        end
    end

    always_comb begin
        scale = (state_n == S_SETTLE) ? real'(k_n) / real'(SETTLE_CYC) : 1.0;
        unit  = iref_500ua / 2.5 * scale;
        for (int i = 0; i < N_THERM; i++) begin
            therm_n[i] = therm_ena[i] ? unit + nz * $sqrt(real'(2 ** N_BIN)) : 0.0;
        end
        for (int b = 0; b < N_BIN; b++) begin
            bin_n[b] = iref_500ua / (2.5 * real'(2 ** (N_BIN - b))) * scale
                       + nz * $sqrt(real'(2 ** b));
        end
        red_n = bin_n[0];
        if (state_n == S_FAULT || state_n == S_OFF) begin
            for (int i = 0; i < N_THERM; i++) therm_n[i] = (state_n == S_OFF) ? Z_REAL : 0.0;
            for (int b = 0; b < N_BIN; b++) bin_n[b] = (state_n == S_OFF) ? Z_REAL : 0.0;
            red_n = (state_n == S_OFF) ? Z_REAL : 0.0;
        end
        sel_val = 0.0;
        for (int i = 0; i < N_THERM; i++) begin
            if (int'(atb_sel) == i) sel_val = therm_n[i];
        end
        atb1_n = Z_REAL;
        atb0_n = Z_REAL;
        case (atb_ena)
            2'b01: begin atb1_n = vddana_1p8; atb0_n = vssana;  end
            2'b10: begin atb1_n = vddana_0p8; atb0_n = sel_val; end
            2'b11: begin atb1_n = iref_500ua; atb0_n = red_n;   end
            default: ;
        endcase
        if (state_n == S_OFF) begin
            atb1_n = Z_REAL;
            atb0_n = Z_REAL;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q      <= S_OFF;
            k_q          <= '0;
            bad_q        <= '0;
            lfsr_q       <= 32'hACE1_5EED;
            ready        <= 1'b0;
            fault        <= 1'b0;
            iout_bin_red <= Z_REAL;
            atb1         <= Z_REAL;
            atb0         <= Z_REAL;
            for (int i = 0; i < N_THERM; i++) iout_therm[i] <= Z_REAL;
            for (int b = 0; b < N_BIN; b++) iout_bin[b] <= Z_REAL;
        end else begin
            state_q      <= state_n;
            k_q          <= k_n;
            bad_q        <= bad_n;
            lfsr_q       <= {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
            ready        <= (state_n == S_ON);
            fault        <= (state_n == S_FAULT);
            iout_bin_red <= red_n;
            atb1         <= atb1_n;
            atb0         <= atb0_n;
            for (int i = 0; i < N_THERM; i++) iout_therm[i] <= therm_n[i];
            for (int b = 0; b < N_BIN; b++) iout_bin[b] <= bin_n[b];
            if (state_n == S_FAULT && state_q != S_FAULT) begin
                $warning("csu_array_seq: fault entry, ok flags iref=%0b vdd1p8=%0b vdd0p8=%0b vss=%0b",
                         iref_ok, v18_ok, v08_ok, vss_ok);
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_csu_array_seq.sv
// Directed bench for csu_array_seq: ramp, debounce, fault exit,
// testbus routing and asynchronous reset.
module tb_csu_array_seq;

    localparam int  NT = 17;
    localparam int  NB = 6;
    localparam real ZR = 1.0e30;

    logic          clk;
    logic          rstb;
    logic          pdb;
    logic [NT-1:0] therm_ena;
    logic [1:0]    atb_ena;
    logic [4:0]    atb_sel;
    real           iref, v18, v08, vss;
    real           therm [NT];
    real           bin [NB];
    real           red, atb1, atb0;
    logic          ready, fault;
    logic [1:0]    state;
    int            total;
    int            bad;

    csu_array_seq #(
        .N_THERM(NT), .N_BIN(NB), .SETTLE_CYC(4), .DEBOUNCE_CYC(3),
        .IREF_NOM(500e-6), .NOISE_EN(0)
    ) dut (
        .clk(clk), .rstb(rstb), .pdb(pdb), .therm_ena(therm_ena),
        .atb_ena(atb_ena), .atb_sel(atb_sel), .iref_500ua(iref),
        .vddana_1p8(v18), .vddana_0p8(v08), .vssana(vss),
        .iout_therm(therm), .iout_bin(bin), .iout_bin_red(red),
        .atb1(atb1), .atb0(atb0), .ready(ready), .fault(fault), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit near(input real a, input real b);
        if (a == ZR || b == ZR) return a == b;
        return (a - b < 1.0e-12) && (b - a < 1.0e-12);
    endfunction

    task automatic chk_r(input string tag, input real obs, input real exp);
        total++;
        assert (near(obs, exp) === 1'b1)
        else begin
            bad++;
            $error("FAIL %s: got %g want %g", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rstb      = 1'b1;
        pdb       = 1'b0;
        therm_ena = '1;
        atb_ena   = 2'b00;
        atb_sel   = 5'd0;
        iref      = 500e-6;
        v18       = 1.8;
        v08       = 0.8;
        vss       = 0.0;
        #1 rstb = 1'b0;
        #1;
        chk_i("rst_state", int'(state), 0);
        chk_i("rst_ready", int'(ready), 0);
        chk_i("rst_fault", int'(fault), 0);
        chk_r("rst_therm0", therm[0], ZR);
        chk_r("rst_atb1", atb1, ZR);
        step();
        rstb = 1'b1;
        step();
        chk_i("off_state", int'(state), 0);
        chk_r("off_red", red, ZR);

        // power-up ramp
        pdb = 1'b1;
        step();
        chk_i("ramp1_state", int'(state), 1);
        chk_r("ramp1_therm0", therm[0], 50e-6);
        chk_r("ramp1_bin5", bin[5], 25e-6);
        step();
        chk_r("ramp2_therm0", therm[0], 100e-6);
        step();
        chk_r("ramp3_therm0", therm[0], 150e-6);
        step();
        chk_r("ramp4_therm0", therm[0], 200e-6);
        chk_i("ramp4_ready", int'(ready), 0);
        step();
        chk_i("on_state", int'(state), 2);
        chk_i("on_ready", int'(ready), 1);
        chk_r("on_bin5", bin[5], 100e-6);
        chk_r("on_bin0", bin[0], 3.125e-6);
        chk_r("on_red", red, 3.125e-6);
        chk_r("on_therm16", therm[16], 200e-6);

        // debounce: two bad samples do not fault
        v18 = 1.6;
        step();
        step();
        v18 = 1.8;
        step();
        chk_i("deb2_state", int'(state), 2);
        chk_i("deb2_fault", int'(fault), 0);
        v18 = 1.6;
        step();
        step();
        chk_i("deb3_pre_state", int'(state), 2);
        step();
        chk_i("deb3_state", int'(state), 3);
        chk_i("deb3_fault", int'(fault), 1);
        chk_i("deb3_ready", int'(ready), 0);
        chk_r("deb3_therm0", therm[0], 0.0);
        chk_r("deb3_bin5", bin[5], 0.0);
        chk_r("deb3_red", red, 0.0);
        v18 = 1.8;
        step();
        chk_i("fault_hold", int'(state), 3);

        // fault exit and fresh ramp
        pdb = 1'b0;
        step();
        chk_i("fexit_state", int'(state), 0);
        chk_i("fexit_fault", int'(fault), 0);
        chk_r("fexit_therm0", therm[0], ZR);
        pdb = 1'b1;
        step();
        chk_r("reramp_therm0", therm[0], 50e-6);
        repeat (4) step();
        chk_i("reon_state", int'(state), 2);

        // testbus
        therm_ena[3] = 1'b0;
        atb_ena      = 2'b10;
        atb_sel      = 5'd3;
        step();
        chk_r("atb10_atb0", atb0, 0.0);
        chk_r("atb10_atb1", atb1, 0.8);
        chk_r("atb10_therm3", therm[3], 0.0);
        atb_sel = 5'd20;
        step();
        chk_r("atb_sel20", atb0, 0.0);
        atb_sel = 5'd16;
        step();
        chk_r("atb_sel16", atb0, 200e-6);
        atb_ena = 2'b11;
        step();
        chk_r("atb11_atb1", atb1, 500e-6);
        chk_r("atb11_atb0", atb0, 3.125e-6);
        atb_ena = 2'b01;
        step();
        chk_r("atb01_atb1", atb1, 1.8);
        chk_r("atb01_atb0", atb0, 0.0);
        atb_ena = 2'b00;
        step();
        chk_r("atb00_atb0", atb0, ZR);

        // async reset mid-ramp
        atb_ena = 2'b11;
        pdb     = 1'b0;
        step();
        chk_r("off_atb0", atb0, ZR);
        chk_r("off_atb1", atb1, ZR);
        pdb = 1'b1;
        step();
        step();
        chk_r("k2_therm0", therm[0], 100e-6);
        #2 rstb = 1'b0;
        #1;
        chk_i("arst_state", int'(state), 0);
        chk_r("arst_therm0", therm[0], ZR);
        chk_r("arst_atb0", atb0, ZR);
        #1 rstb = 1'b1;
        step();
        chk_i("rerst_state", int'(state), 1);
        chk_r("rerst_therm0", therm[0], 50e-6);
        repeat (4) step();
        chk_i("rerst_on", int'(state), 2);

        // pdb=0 coincides with third bad sample
        v18 = 1.6;
        step();
        step();
        pdb = 1'b0;
        step();
        chk_i("race_state", int'(state), 0);
        chk_i("race_fault", int'(fault), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
